rv_instr_packer: RTL and testbench

- Write-side counterpart of the instruction fetch/decode path.
- Accepts R-type instruction fields over a valid/ready handshake and packs them into 32-bit RISC-V words.
- Buffers the packed words in a small FIFO, then writes them sequentially into the instruction RAM from address 0.
- The decode path later reads the RAM with its own read pointer and splits each word back into the same fields.

---
 rtl/rv_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/rv_instr_packer.sv | 115 +++++++++++
 tb/tb_rv_instr_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the R-type instruction packer and the decode path.
// Field bit positions, the RTYPE opcode, the stream FSM states and a field-packing helper.
package rv_pkg;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  function automatic logic [31:0] pack_rtype(
    input logic [6:0] funct7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] funct3,
    input logic [4:0] rd,
    input logic [6:0] opcode
  );
    logic [31:0] w;
    w = '0;
    w[F7_LSB  +: 7] = funct7;
    w[RS2_LSB +: 5] = rs2;
    w[RS1_LSB +: 5] = rs1;
    w[F3_LSB  +: 3] = funct3;
    w[RD_LSB  +: 5] = rd;
    w[OPC_LSB +: 7] = opcode;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with head-of-queue output: a push is visible on head_dat the next cycle.
// Push is ignored when full and pop when empty; a pop never frees space for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full     = (cnt_q == LVL_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign level    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rv_instr_packer.sv
// Packs R-type fields into 32-bit words and streams them into instruction RAM from address 0.
// One cycle from accept to mem_we when idle; in_ready drops when the FIFO is full, done, or clearing.
module rv_instr_packer
  import rv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  opcode,
  input  logic [4:0]                  rd,
  input  logic [2:0]                  funct3,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic [6:0]                  funct7,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [WIDTH-1:0]            mem_wdata,
  input  logic                        mem_ready,
  output logic                        done,
  output logic [7:0]                  illegal_cnt,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        ill_q, ill_d;

  logic             full, empty;
  logic [WIDTH-1:0] head_dat;
  logic             accept, legal, push, wr_done;

  // Every 32-bit RISC-V opcode shares the RTYPE low bits 2'b11.
  assign legal    = (opcode[1:0] == OPC_RTYPE[1:0]);
  assign in_ready = !full && (state_q != DONE) && !clear;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign mem_we   = (state_q == STREAM) && !empty;
  assign wr_done  = mem_we && mem_ready && !clear;

  assign mem_addr    = addr_q;
  assign mem_wdata   = empty ? '0 : head_dat;
  assign done        = (state_q == DONE);
  assign illegal_cnt = ill_q;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clear),
    .push    (push),
    .push_dat(pack_rtype(funct7, rs2, rs1, funct3, rd, opcode)),
    .pop     (wr_done),
    .head_dat(head_dat),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ill_d   = ill_q;
    if (accept && !legal && ill_q != 8'hFF) begin
      ill_d = ill_q + 8'd1;
    end
    if (clear) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) state_d = STREAM;
        end
        STREAM: begin
          if (wr_done) begin
            // The last address is written once; the counter never wraps.
            if (addr_q == LAST_ADDR) begin
              state_d = DONE;
            end else begin
              addr_d = addr_q + 1'b1;
              if (level == LVL_W'(1) && !push) state_d = IDLE;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ill_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_rv_instr_packer.sv
// Bench for rv_instr_packer: table of packing vectors, directed corner sequences, random traffic vs a queue model.
module tb_rv_instr_packer;

  localparam int FD = 4;
  localparam int MW = 32;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, mem_ready;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        in_ready, mem_we, done;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  illegal_cnt;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO is a queue of words, plus write address, done flag and drop count.
  logic [31:0] mq[$];
  int          m_addr;
  bit          m_done;
  int          m_ill;

  rv_instr_packer dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .done(done), .illegal_cnt(illegal_cnt), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_rdy();
    return (mq.size() < FD) && !m_done && !clear;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_addr = 0;
    m_done = 0;
    m_ill  = 0;
  endtask

  task automatic model_step();
    bit rdy, we;
    if (rst) begin
      model_reset();
      return;
    end
    if (clear) begin
      mq.delete();
      m_addr = 0;
      m_done = 0;
      return;
    end
    rdy = model_rdy();
    we  = !m_done && (mq.size() > 0);
    if (we && mem_ready) begin
      void'(mq.pop_front());
      if (m_addr == MW - 1) m_done = 1;
      else m_addr++;
    end
    if (in_valid && rdy) begin
      if (opcode[1:0] == 2'b11) mq.push_back({funct7, rs2, rs1, funct3, rd, opcode});
      else if (m_ill < 255) m_ill++;
    end
  endtask

  task automatic check_model();
    bit we;
    we = !m_done && (mq.size() > 0);
    chk("in_ready", in_ready, model_rdy());
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, (mq.size() > 0) ? mq[0] : 32'd0);
    chk("done", done, m_done);
    chk("illegal_cnt", illegal_cnt, m_ill);
    chk("level", level, mq.size());
  endtask

  // Inputs change at posedge+1; outputs are compared with the model at the negedge.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_fields(input bit legal_only);
    funct7 = 7'($urandom);
    rs2    = 5'($urandom);
    rs1    = 5'($urandom);
    funct3 = 3'($urandom);
    rd     = 5'($urandom);
    opcode = 7'($urandom);
    if (legal_only || $urandom_range(0, 9) != 0) opcode[1:0] = 2'b11;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    bit          legal;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    int waddr, nill, sent, last_wa;

    vt[0] = '{7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 1'b1, 32'h002081B3};
    vt[1] = '{7'h33, 5'd2,  3'd0, 5'd1,  5'd2,  7'h20, 1'b1, 32'h40208133};
    vt[2] = '{7'h7F, 5'h1F, 3'd7, 5'h1F, 5'h1F, 7'h7F, 1'b1, 32'hFFFFFFFF};
    vt[3] = '{7'h33, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 1'b1, 32'h00000033};
    vt[4] = '{7'h0C, 5'd9,  3'd1, 5'd4,  5'd6,  7'h01, 1'b0, 32'h00000000};
    vt[5] = '{7'h33, 5'd5,  3'd4, 5'd6,  5'd7,  7'h00, 1'b1, 32'h007342B3};
    vt[6] = '{7'h3B, 5'h0A, 3'd5, 5'h15, 5'h0A, 7'h55, 1'b1, 32'hAAAAD53B};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; funct7 = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 rst = 1'b0;

    chk("rst_mem_we", mem_we, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal_cnt", illegal_cnt, 0);
    chk("rst_level", level, 0);

    // Packing table: one word at a time, written immediately.
    waddr = 0;
    nill  = 0;
    for (int i = 0; i < 7; i++) begin
      opcode = vt[i].op; rd = vt[i].rd; funct3 = vt[i].f3;
      rs1 = vt[i].rs1; rs2 = vt[i].rs2; funct7 = vt[i].f7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (vt[i].legal) begin
        chk("vec_we", mem_we, 1);
        chk("vec_wdata", mem_wdata, vt[i].exp);
        chk("vec_addr", mem_addr, waddr);
        tick();
        waddr++;
        chk("vec_addr_after", mem_addr, waddr);
        chk("vec_idle_we", mem_we, 0);
      end else begin
        nill++;
        chk("vec_drop_we", mem_we, 0);
        chk("vec_drop_cnt", illegal_cnt, nill);
      end
    end

    // Backpressure: fill the FIFO with mem_ready low, then drain.
    clear = 1'b1; tick(); clear = 1'b0;
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      opcode = 7'h33; funct3 = 3'd0; rs1 = 5'd1; rs2 = 5'd2; funct7 = 7'h20; rd = 5'(k + 1);
      in_valid = 1'b1;
      tick();
    end
    rd = 5'd5;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_level", level, 4);
    tick();
    chk("bp_level_hold", level, 4);
    in_valid = 1'b0;
    tick();
    chk("bp_addr_hold", mem_addr, 0);
    chk("bp_wdata_hold", mem_wdata, 32'h400080B3 | 32'h00200000);
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_we", mem_we, 1);
      chk("bp_addr", mem_addr, k);
      chk("bp_wdata", mem_wdata, 32'h40208033 | (32'(k + 1) << 7));
      tick();
    end
    chk("bp_drained_we", mem_we, 0);
    chk("bp_drained_level", level, 0);

    // Illegal opcode drops and counter saturation.
    opcode = 7'h30; in_valid = 1'b1;
    tick();
    chk("ill_we", mem_we, 0);
    chk("ill_cnt", illegal_cnt, nill + 1);
    for (int k = 0; k < 299; k++) tick();
    in_valid = 1'b0;
    chk("ill_sat", illegal_cnt, 255);
    chk("ill_level", level, 0);

    // Fill the whole RAM, then confirm DONE blocks further input.
    clear = 1'b1; tick(); clear = 1'b0;
    sent = 0; last_wa = -1;
    for (int c = 0; c < 200 && !m_done; c++) begin
      in_valid = (sent < MW);
      rand_fields(1'b1);
      if (mem_we && mem_ready) last_wa = mem_addr;
      if (in_valid && model_rdy()) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("full_done", done, 1);
    chk("full_last_addr", last_wa, MW - 1);
    chk("full_addr_hold", mem_addr, MW - 1);
    chk("full_in_ready", in_ready, 0);
    rand_fields(1'b1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("extra_level", level, 0);
    chk("extra_we", mem_we, 0);
    chk("extra_done", done, 1);

    // Reach DONE with two words left over, then clear.
    clear = 1'b1; tick(); clear = 1'b0;
    sent = 0;
    for (int c = 0; c < 200; c++) begin
      if (m_addr == MW - 2 && mq.size() == 0) break;
      in_valid = (sent < MW - 2);
      rand_fields(1'b1);
      if (in_valid && model_rdy()) sent++;
      tick();
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rand_fields(1'b1); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    mem_ready = 1'b1;
    tick(); tick();
    chk("left_done", done, 1);
    chk("left_level", level, 2);
    chk("left_we", mem_we, 0);
    clear = 1'b1;
    chk("clear_in_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_level", level, 0);
    chk("clear_addr", mem_addr, 0);
    chk("clear_ill_kept", illegal_cnt, 255);

    // Reset during a stalled write.
    mem_ready = 1'b0;
    rand_fields(1'b1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_we", mem_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_we", mem_we, 0);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_level", level, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_ill", illegal_cnt, 0);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rand_fields(1'b0);
      in_valid  = ($urandom_range(0, 9) < 6);
      mem_ready = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 59) == 0);
      tick();
    end
    clear = 1'b0; in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
